// File: rtl/arm_mc_controller_if.sv
// Control and status bundle between the multicycle ARM controller and its datapath.
interface arm_mc_controller_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite;
    logic         AdrSrc;
    logic         MemWrite;
    logic         IRWrite;
    logic [1:0]   ResultSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ImmSrc;
    logic [1:0]   RegSrc;
    logic         RegWrite;
    logic         LinkSel;
    logic [3:0]   ALUControl;
    logic         FP;
    logic         B;
    logic [3:0]   State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegSrc, RegWrite, LinkSel, ALUControl, FP, B, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegSrc, RegWrite, LinkSel, ALUControl, FP, B, State
    );
endinterface

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: instruction sequencing FSM, NZCV flags and condition gating.
// Control outputs are registered from the next state, so they are valid from the start of each state.
module arm_mc_controller #(
    parameter bit FP_EN = 1'b1,
    parameter bit BL_EN = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    arm_mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXECR  = 4'd6, EXECI = 4'd7,
        ALUWB  = 4'd8,  BRANCH = 4'd9,  FPEX   = 4'd10
    } state_t;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic       sa;
        logic [1:0] sb;
        logic       rw;
        logic       ls;
        logic [3:0] ac;
        logic       fp;
        logic       b;
    } ctl_t;

    state_t     state, state_nx, state_ld;
    ctl_t       ctl_d, ctl_q;
    logic [3:0] flags;
    logic       cond_ex, cond_ex_nx, cond_ok;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd, cond, rd, dp_ctl;
    logic       no_write, wb_ok;
    logic [1:0] flag_w;
    logic       unused_bits;

    assign cond  = bus.Instr[31:28];
    assign op    = bus.Instr[27:26];
    assign funct = bus.Instr[25:20];
    assign rd    = bus.Instr[15:12];
    assign cmd   = funct[4:1];
    assign unused_bits = ^bus.Instr[19:16];

    always_comb begin
        dp_ctl   = 4'b0000;
        no_write = 1'b1;
        case (cmd)
            4'b0100: begin dp_ctl = 4'b0000; no_write = 1'b0; end
            4'b0010: begin dp_ctl = 4'b0001; no_write = 1'b0; end
            4'b0000: begin dp_ctl = 4'b0010; no_write = 1'b0; end
            4'b1100: begin dp_ctl = 4'b0011; no_write = 1'b0; end
            4'b1010: begin dp_ctl = 4'b0001; no_write = 1'b1; end
            default: begin dp_ctl = 4'b0000; no_write = 1'b1; end
        endcase
        // FP ops only ever touch N and Z
        if (op == 2'b11)
            flag_w = {funct[0], 1'b0};
        else
            flag_w = {funct[0], funct[0] & (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)};
    end

    always_comb begin
        case (cond)
            4'b0000: cond_ok = flags[2];
            4'b0001: cond_ok = ~flags[2];
            4'b0010: cond_ok = flags[1];
            4'b0011: cond_ok = ~flags[1];
            4'b0100: cond_ok = flags[3];
            4'b0101: cond_ok = ~flags[3];
            4'b0110: cond_ok = flags[0];
            4'b0111: cond_ok = ~flags[0];
            4'b1000: cond_ok = flags[1] & ~flags[2];
            4'b1001: cond_ok = ~flags[1] | flags[2];
            4'b1010: cond_ok = (flags[3] == flags[0]);
            4'b1011: cond_ok = (flags[3] != flags[0]);
            4'b1100: cond_ok = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ok = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:  state_nx = DECODE;
            DECODE: case (op)
                        2'b00:   state_nx = funct[5] ? EXECI : EXECR;
                        2'b01:   state_nx = MEMADR;
                        2'b10:   state_nx = BRANCH;
                        default: state_nx = FP_EN ? FPEX : FETCH;
                    endcase
            MEMADR: state_nx = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_nx = MEMWB;
            EXECR, EXECI, FPEX: state_nx = ALUWB;
            default: state_nx = FETCH;
        endcase

        state_ld   = reset ? FETCH : state_nx;
        cond_ex_nx = reset ? 1'b0 : ((state == DECODE) ? cond_ok : cond_ex);
        wb_ok      = cond_ex_nx & (~no_write | (op == 2'b11));

        ctl_d = '0;
        case (state_ld)
            FETCH:  begin
                ctl_d.irw = 1'b1; ctl_d.sa = 1'b1; ctl_d.sb = 2'b10;
                ctl_d.rs  = 2'b10; ctl_d.pcw = 1'b1;
            end
            DECODE: begin ctl_d.sa = 1'b1; ctl_d.sb = 2'b10; ctl_d.rs = 2'b10; end
            MEMADR: ctl_d.sb = 2'b01;
            MEMRD:  ctl_d.adr = 1'b1;
            MEMWB:  begin
                ctl_d.rs  = 2'b01;
                ctl_d.rw  = cond_ex_nx;
                ctl_d.pcw = cond_ex_nx & (rd == 4'hF);
            end
            MEMWR:  begin ctl_d.adr = 1'b1; ctl_d.mw = cond_ex_nx; end
            EXECR:  ctl_d.ac = dp_ctl;
            EXECI:  begin ctl_d.sb = 2'b01; ctl_d.ac = dp_ctl; end
            FPEX:   begin ctl_d.fp = 1'b1; ctl_d.ac = {2'b10, funct[2:1]}; end
            ALUWB:  begin ctl_d.rw = wb_ok; ctl_d.pcw = wb_ok & (rd == 4'hF); end
            BRANCH: begin
                ctl_d.sb  = 2'b01; ctl_d.rs = 2'b10;
                ctl_d.pcw = cond_ex_nx; ctl_d.b = cond_ex_nx;
                ctl_d.rw  = cond_ex_nx & BL_EN & bus.Instr[24];
                ctl_d.ls  = cond_ex_nx & BL_EN & bus.Instr[24];
            end
            default: ctl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            flags   <= 4'b0000;
            cond_ex <= 1'b0;
        end else begin
            state   <= state_nx;
            cond_ex <= cond_ex_nx;
            if (cond_ex && (state == EXECR || state == EXECI || state == FPEX)) begin
                if (flag_w[1]) flags[3:2] <= bus.ALUFlags[3:2];
                if (flag_w[0]) flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
        ctl_q <= ctl_d;
    end

    // write enables are masked combinationally so nothing is written in a reset cycle
    assign bus.PCWrite    = ctl_q.pcw & ~reset;
    assign bus.IRWrite    = ctl_q.irw & ~reset;
    assign bus.MemWrite   = ctl_q.mw  & ~reset;
    assign bus.RegWrite   = ctl_q.rw  & ~reset;
    assign bus.LinkSel    = ctl_q.ls  & ~reset;
    assign bus.AdrSrc     = ctl_q.adr;
    assign bus.ResultSrc  = ctl_q.rs;
    assign bus.ALUSrcA    = ctl_q.sa;
    assign bus.ALUSrcB    = ctl_q.sb;
    assign bus.ALUControl = ctl_q.ac;
    assign bus.FP         = ctl_q.fp;
    assign bus.B          = ctl_q.b;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
    assign bus.State      = state;
endmodule
